mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: one dcache request per load/store,
// load alignment/extension, bus-fault and timeout reporting.

package mem_access_pkg;

  typedef enum logic [2:0] {
    UNIT_NONE,
    UNIT_ALU,
    UNIT_BRANCH,
    UNIT_MUL,
    UNIT_CSR,
    UNIT_MEM,
    UNIT_AMO
  } unit_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } op_size_t;

  localparam logic [3:0] CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } except_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    unit_t       unit;
    logic        mem_wr;
    op_size_t    op_size;
    logic        op_unsigned;
    logic [4:0]  rd;
    except_t     except;
  } issued_instr_t;

  function automatic except_t except_fault(
    input logic [3:0]  cause,
    input logic [31:0] addr
  );
    except_t e;
    e.valid = 1'b1;
    e.cause = cause;
    e.tval  = addr;
    return e;
  endfunction

  function automatic issued_instr_t compose_issued_instr(
    input issued_instr_t ins,
    input except_t       e
  );
    issued_instr_t r;
    r        = ins;
    r.except = e;
    return r;
  endfunction

endpackage

`define EXCEPT_LOAD_FAULT(a) \
  mem_access_pkg::except_fault(mem_access_pkg::CAUSE_LOAD_FAULT, (a))
`define EXCEPT_STORE_FAULT(a) \
  mem_access_pkg::except_fault(mem_access_pkg::CAUSE_STORE_FAULT, (a))

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_stall,
  input  issued_instr_t i_instr,
  input  logic [31:0]   i_data,
  input  logic [31:0]   i_data_rs2,
  output logic          o_stall,
  output issued_instr_t o_instr,
  output logic [31:0]   o_data,
  output logic          o_req_valid,
  output logic          o_req_wr,
  output logic [31:0]   o_req_addr,
  output logic [3:0]    o_req_mask,
  output logic [31:0]   o_req_wdata,
  input  logic          i_req_ready,
  input  logic          i_resp_valid,
  input  logic          i_resp_fault,
  input  logic [31:0]   i_resp_data
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN
  } state_t;

  function automatic logic [3:0] f_mask(
    input op_size_t   s,
    input logic [1:0] off
  );
    case (s)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      default: return 4'b1111 << off;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(
    input op_size_t    s,
    input logic [31:0] d
  );
    case (s)
      SIZE_B:  return {4{d[7:0]}};
      SIZE_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_load(
    input op_size_t    s,
    input logic        uns,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d >> {off, 3'b000};
    case (s)
      SIZE_B:
        return uns ? {24'b0, w[7:0]}
                   : {{24{w[7]}}, w[7:0]};
      SIZE_H:
        return uns ? {16'b0, w[15:0]}
                   : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  issued_instr_t r_instr;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;
  logic          r_wr;

  logic          r_gate;
  logic          r_pend;
  issued_instr_t r_pend_instr;
  logic [31:0]   r_pend_data;
  issued_instr_t r_out_instr;
  logic [31:0]   r_out_data;

  logic          w_is_mem;
  logic          w_elig;
  logic          w_hs;
  logic          w_tmo;
  logic          w_fin;
  logic          w_fault;
  issued_instr_t w_res_instr;
  logic [31:0]   w_res_data;
  logic          w_out_we;
  issued_instr_t w_nxt_instr;
  logic [31:0]   w_nxt_data;

  assign w_is_mem = i_instr.valid
                  & (i_instr.unit == UNIT_MEM)
                  & ~i_instr.except.valid;

  // A held instruction whose result is pending is already consumed.
  assign w_elig = (r_state == S_IDLE) & w_is_mem
                & ~i_stall & ~i_flush
                & ~r_gate & ~r_pend;

  assign w_hs  = o_req_valid & i_req_ready;

  assign w_tmo = (r_state == S_RESP) & ~i_resp_valid
               & (r_cnt == CNT_LAST);

  assign w_fin = (r_state == S_RESP)
               & (i_resp_valid | w_tmo) & ~i_flush;

  assign w_fault = w_tmo | i_resp_fault;

  assign o_stall = i_stall
                 | ((w_elig | (r_state != S_IDLE))
                    & ~w_fin & ~r_pend);

  assign o_instr = r_out_instr;
  assign o_data  = r_out_data;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_elig)
          w_state_nxt = i_req_ready ? S_RESP : S_REQ;
      S_REQ:
        if (i_flush)          w_state_nxt = S_IDLE;
        else if (i_req_ready) w_state_nxt = S_RESP;
      S_RESP:
        if (i_flush)           w_state_nxt = S_DRAIN;
        else if (i_resp_valid) w_state_nxt = S_IDLE;
        else if (w_tmo)        w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (i_resp_valid && !i_flush)
          w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request outputs: live from execute on arrival, then held copy.
  always_comb begin
    o_req_valid = 1'b0;
    o_req_wr    = 1'b0;
    o_req_addr  = '0;
    o_req_mask  = '0;
    o_req_wdata = '0;
    if (w_elig) begin
      o_req_valid = 1'b1;
      o_req_wr    = i_instr.mem_wr;
      o_req_addr  = {i_data[31:2], 2'b00};
      o_req_mask  = f_mask(i_instr.op_size, i_data[1:0]);
      o_req_wdata = f_wdata(i_instr.op_size, i_data_rs2);
    end else if (r_state == S_REQ && !i_flush) begin
      o_req_valid = 1'b1;
      o_req_wr    = r_wr;
      o_req_addr  = {r_addr[31:2], 2'b00};
      o_req_mask  = r_mask;
      o_req_wdata = r_wdata;
    end
  end

  // Response timeout counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (w_hs)
      r_cnt <= '0;
    else if (r_state == S_RESP && !i_resp_valid && !w_tmo)
      r_cnt <= r_cnt + 1'b1;
  end

  // Completed access: aligned load data or a fault.
  always_comb begin
    w_res_instr = r_instr;
    w_res_data  = '0;
    if (w_fault)
      w_res_instr = compose_issued_instr(
        r_instr,
        r_wr ? `EXCEPT_STORE_FAULT(r_addr)
             : `EXCEPT_LOAD_FAULT(r_addr));
    else if (!r_wr)
      w_res_data = f_load(r_instr.op_size,
                          r_instr.op_unsigned,
                          r_addr[1:0], i_resp_data);
  end

  // Select what leaves the stage this cycle.
  always_comb begin
    w_out_we    = ~i_stall;
    w_nxt_instr = '0;
    w_nxt_data  = '0;
    if (r_pend) begin
      w_nxt_instr = r_pend_instr;
      w_nxt_data  = r_pend_data;
    end else if (w_fin) begin
      w_nxt_instr = w_res_instr;
      w_nxt_data  = w_res_data;
    end else if (r_state == S_IDLE && !w_elig) begin
      w_nxt_instr = i_instr;
      w_nxt_data  = i_data;
      if (r_gate) w_nxt_instr.valid = 1'b0;
    end
  end

  // Request capture, output registers, pending result, gating.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_instr      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_wr         <= 1'b0;
      r_gate       <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_instr <= '0;
      r_pend_data  <= '0;
      r_out_instr  <= '0;
      r_out_data   <= '0;
    end else begin
      if (w_elig) begin
        r_instr <= i_instr;
        r_addr  <= i_data;
        r_mask  <= f_mask(i_instr.op_size, i_data[1:0]);
        r_wdata <= f_wdata(i_instr.op_size, i_data_rs2);
        r_wr    <= i_instr.mem_wr;
      end
      if (i_flush) begin
        r_out_instr <= '0;
        r_out_data  <= '0;
        r_gate      <= 1'b0;
        r_pend      <= 1'b0;
      end else if (w_out_we) begin
        r_out_instr <= w_nxt_instr;
        r_out_data  <= w_nxt_data;
        r_pend      <= 1'b0;
        if (w_nxt_instr.valid && w_nxt_instr.except.valid)
          r_gate <= 1'b1;
      end else if (w_fin) begin
        r_pend       <= 1'b1;
        r_pend_instr <= w_res_instr;
        r_pend_data  <= w_res_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus
// hand sequences for stall, flush, timeout and gating.

module tb_mem_access;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, stall;
  issued_instr_t ins;
  logic [31:0]   data, rs2;
  logic          ostall;
  issued_instr_t oins;
  logic [31:0]   odata;
  logic          rv, rwr;
  logic [31:0]   raddr, rwd;
  logic [3:0]    rmask;
  logic          ready, resp_v, resp_f;
  logic [31:0]   resp_d;

  int n_chk = 0;
  int n_fail = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_stall      (stall),
    .i_instr      (ins),
    .i_data       (data),
    .i_data_rs2   (rs2),
    .o_stall      (ostall),
    .o_instr      (oins),
    .o_data       (odata),
    .o_req_valid  (rv),
    .o_req_wr     (rwr),
    .o_req_addr   (raddr),
    .o_req_mask   (rmask),
    .o_req_wdata  (rwd),
    .i_req_ready  (ready),
    .i_resp_valid (resp_v),
    .i_resp_fault (resp_f),
    .i_resp_data  (resp_d)
  );

  typedef struct {
    logic          mem;
    issued_instr_t ins;
    logic [31:0]   data;
    logic [31:0]   rs2;
    logic [31:0]   rdata;
    logic [3:0]    mask;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm,
                      input issued_instr_t act,
                      input issued_instr_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic issued_instr_t mk(input unit_t u,
                                       input logic wr,
                                       input op_size_t s,
                                       input logic uns,
                                       input logic [31:0] pc);
    issued_instr_t r;
    r             = '0;
    r.valid       = 1'b1;
    r.pc          = pc;
    r.unit        = u;
    r.mem_wr      = wr;
    r.op_size     = s;
    r.op_unsigned = uns;
    r.rd          = 5'd3;
    return r;
  endfunction

  vec_t          tab [12];
  issued_instr_t e, ef, add;
  int            cnt;

  initial begin
    tab[0]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_W, 0, 32'h100),
                32'h1000, 32'h0, 32'hDEADBEEF,
                4'b1111, 32'h0, 32'hDEADBEEF};
    tab[1]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_B, 0, 32'h104),
                32'h1003, 32'h0, 32'h80FF0000,
                4'b1000, 32'h0, 32'hFFFFFF80};
    tab[2]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_B, 1, 32'h108),
                32'h1003, 32'h0, 32'h80FF0000,
                4'b1000, 32'h0, 32'h00000080};
    tab[3]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_H, 0, 32'h10C),
                32'h1002, 32'h0, 32'h80FF0000,
                4'b1100, 32'h0, 32'hFFFF80FF};
    tab[4]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_H, 1, 32'h110),
                32'h1000, 32'h0, 32'h1234F00D,
                4'b0011, 32'h0, 32'h0000F00D};
    tab[5]  = '{1'b1, mk(UNIT_MEM, 0, SIZE_B, 0, 32'h114),
                32'h1001, 32'h0, 32'h00007F00,
                4'b0010, 32'h0, 32'h0000007F};
    tab[6]  = '{1'b1, mk(UNIT_MEM, 1, SIZE_B, 0, 32'h118),
                32'h3001, 32'h000000A5, 32'h0,
                4'b0010, 32'hA5A5A5A5, 32'h0};
    tab[7]  = '{1'b1, mk(UNIT_MEM, 1, SIZE_W, 0, 32'h11C),
                32'h3004, 32'hCAFEF00D, 32'h0,
                4'b1111, 32'hCAFEF00D, 32'h0};
    tab[8]  = '{1'b0, mk(UNIT_ALU, 0, SIZE_W, 0, 32'h900),
                32'h11, 32'h0, 32'h0, 4'b0, 32'h0, 32'h11};
    tab[9]  = '{1'b0, mk(UNIT_AMO, 0, SIZE_W, 0, 32'h904),
                32'h22, 32'h5, 32'h0, 4'b0, 32'h0, 32'h22};
    tab[10] = '{1'b0, '0,
                32'h33, 32'h0, 32'h0, 4'b0, 32'h0, 32'h33};
    tab[11] = '{1'b0, mk(UNIT_MUL, 0, SIZE_W, 0, 32'h908),
                32'h44, 32'h0, 32'h0, 4'b0, 32'h0, 32'h44};

    ins = '0; data = '0; rs2 = '0;
    ready = 0; resp_v = 0; resp_f = 0; resp_d = '0;
    flush = 0; stall = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    #1;
    chki("rst_instr", oins, '0);
    chk("rst_data", odata, 32'h0);
    chk("rst_req_valid", 32'(rv), 32'h0);
    chk("rst_req_wr", 32'(rwr), 32'h0);
    chk("rst_req_addr", raddr, 32'h0);
    chk("rst_req_mask", 32'(rmask), 32'h0);
    chk("rst_req_wdata", rwd, 32'h0);
    chk("rst_stall", 32'(ostall), 32'h0);

    foreach (tab[i]) begin
      ins  = tab[i].ins;
      data = tab[i].data;
      rs2  = tab[i].rs2;
      ready = tab[i].mem;
      #1;
      if (tab[i].mem) begin
        chk("vec_req_valid", 32'(rv), 32'h1);
        chk("vec_req_wr", 32'(rwr), 32'(tab[i].ins.mem_wr));
        chk("vec_req_addr", raddr,
            {tab[i].data[31:2], 2'b00});
        chk("vec_req_mask", 32'(rmask), 32'(tab[i].mask));
        chk("vec_req_wdata", rwd, tab[i].wdata);
        chk("vec_stall_arr", 32'(ostall), 32'h1);
        step();
        ready  = 0;
        resp_v = 1;
        resp_d = tab[i].rdata;
        #1;
        chk("vec_stall_resp", 32'(ostall), 32'h0);
        step();
        resp_v = 0;
        ins    = '0;
        data   = '0;
        #1;
        chki("vec_out_instr", oins, tab[i].ins);
        chk("vec_out_data", odata, tab[i].exp);
        chk("vec_stall_after", 32'(ostall), 32'h0);
      end else begin
        chk("pass_req_valid", 32'(rv), 32'h0);
        chk("pass_stall", 32'(ostall), 32'h0);
        step();
        ins  = '0;
        data = '0;
        #1;
        chki("pass_instr", oins, tab[i].ins);
        chk("pass_data", odata, tab[i].exp);
      end
    end

    // halfword store held off by the dcache for three cycles
    e = mk(UNIT_MEM, 1, SIZE_H, 0, 32'h200);
    ins = e; data = 32'h2002; rs2 = 32'h1234ABCD;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      ready = (c == 3);
      #1;
      if (rv === 1'b1 && rwr === 1'b1 &&
          raddr === 32'h2000 && rmask === 4'b1100 &&
          rwd === 32'hABCDABCD)
        cnt++;
      step();
    end
    chk("sh_req_stable", 32'(cnt), 32'd4);
    ready = 0; resp_v = 1; resp_d = 32'hFFFFFFFF;
    #1;
    step();
    resp_v = 0; ins = '0; data = '0; rs2 = '0;
    #1;
    chki("sh_out_instr", oins, e);
    chk("sh_out_data", odata, 32'h0);

    // flush one cycle after acceptance, response two cycles later
    e = mk(UNIT_MEM, 0, SIZE_W, 0, 32'h300);
    ins = e; data = 32'h1000; ready = 1;
    #1;
    step();
    ready = 0; ins = '0; data = '0; flush = 1;
    #1;
    step();
    flush = 0;
    #1;
    chk("fl_stall_d1", 32'(ostall), 32'h1);
    chk("fl_req_d1", 32'(rv), 32'h0);
    chk("fl_valid_d1", 32'(oins.valid), 32'h0);
    step();
    resp_v = 1; resp_d = 32'h12345678;
    #1;
    chk("fl_stall_d2", 32'(ostall), 32'h1);
    step();
    resp_v = 0;
    #1;
    chk("fl_valid_end", 32'(oins.valid), 32'h0);
    chk("fl_data_end", odata, 32'h0);
    chk("fl_stall_end", 32'(ostall), 32'h0);

    // timeout with no response, then gating until flush
    e = mk(UNIT_MEM, 0, SIZE_H, 1, 32'h400);
    ins = e; data = 32'h4006; ready = 1;
    #1;
    step();
    ready = 0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ostall === 1'b1) cnt++;
      step();
    end
    chk("to_stall_wait", 32'(cnt), 32'd3);
    #1;
    chk("to_stall_last", 32'(ostall), 32'h0);
    step();
    add = mk(UNIT_ALU, 0, SIZE_W, 0, 32'h404);
    ins = add; data = 32'h77;
    #1;
    ef = e;
    ef.except.valid = 1'b1;
    ef.except.cause = 4'd5;
    ef.except.tval  = 32'h4006;
    chki("to_fault_instr", oins, ef);
    chk("to_fault_data", odata, 32'h0);
    chk("to_drain_stall", 32'(ostall), 32'h1);
    resp_v = 1;
    step();
    resp_v = 0;
    #1;
    step();
    chk("gate_valid", 32'(oins.valid), 32'h0);
    flush = 1;
    step();
    flush = 0;
    #1;
    chki("gate_flush_out", oins, '0);
    step();
    chki("gate_released", oins, add);
    chk("gate_rel_data", odata, 32'h77);

    // store with bus error
    e = mk(UNIT_MEM, 1, SIZE_W, 0, 32'h500);
    ins = e; data = 32'h5008; rs2 = 32'h1; ready = 1;
    #1;
    step();
    ready = 0; ins = '0; data = '0;
    resp_v = 1; resp_f = 1;
    #1;
    step();
    resp_v = 0; resp_f = 0;
    #1;
    ef = e;
    ef.except.valid = 1'b1;
    ef.except.cause = 4'd7;
    ef.except.tval  = 32'h5008;
    chki("st_fault_instr", oins, ef);
    flush = 1;
    step();
    flush = 0;

    // load already carrying an exception
    e = mk(UNIT_MEM, 0, SIZE_W, 0, 32'h600);
    e.except.valid = 1'b1;
    e.except.cause = 4'd4;
    e.except.tval  = 32'h601;
    ins = e; data = 32'h601;
    #1;
    chk("exc_req_valid", 32'(rv), 32'h0);
    chk("exc_stall", 32'(ostall), 32'h0);
    step();
    ins = '0; data = '0;
    #1;
    chki("exc_pass_instr", oins, e);
    chk("exc_pass_data", odata, 32'h601);
    flush = 1;
    step();
    flush = 0;

    // response lands while writeback stalls
    e = mk(UNIT_MEM, 0, SIZE_B, 1, 32'h700);
    ins = e; data = 32'h1002; ready = 1;
    #1;
    step();
    ready = 0; stall = 1; resp_v = 1; resp_d = 32'h00AB0000;
    #1;
    step();
    resp_v = 0;
    #1;
    chk("stl_hold_valid", 32'(oins.valid), 32'h0);
    chk("stl_hold_data", odata, 32'h0);
    chk("stl_stall_hi", 32'(ostall), 32'h1);
    step();
    stall = 0;
    #1;
    chk("stl_pend_stall", 32'(ostall), 32'h0);
    step();
    ins = '0; data = '0;
    #1;
    chki("stl_out_instr", oins, e);
    chk("stl_out_data", odata, 32'h000000AB);

    // stray response in idle
    data = 32'h55; resp_v = 1; resp_d = 32'h999;
    #1;
    step();
    resp_v = 0;
    #1;
    chk("stray_valid", 32'(oins.valid), 32'h0);
    chk("stray_data", odata, 32'h55);
    chk("stray_stall", 32'(ostall), 32'h0);

    // reset in the middle of a transaction
    e = mk(UNIT_MEM, 0, SIZE_W, 0, 32'h800);
    ins = e; data = 32'h1000; ready = 1;
    #1;
    step();
    ready = 0; ins = '0; data = '0; rst_n = 0;
    #1;
    step();
    rst_n = 1;
    #1;
    chk("rmid_stall", 32'(ostall), 32'h0);
    chk("rmid_req_valid", 32'(rv), 32'h0);
    chk("rmid_data", odata, 32'h0);
    resp_v = 1; resp_d = 32'hABCD;
    #1;
    step();
    resp_v = 0;
    #1;
    chk("rmid_after_valid", 32'(oins.valid), 32'h0);
    chk("rmid_after_data", odata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
